// File: rtl/fetch_unit_if.sv
// Instruction memory port used by the fetch stage: the fetch unit drives
// addr/req and the memory returns rdata alongside ready.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] mem_addr;
  logic            mem_req;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_addr, output mem_req, input mem_ready, input mem_rdata);
  modport slave  (input mem_addr, input mem_req, output mem_ready, output mem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC and instruction register, one word per instruction.
// Optional FETCH_MISALIGN_CHECK_EN traps misaligned redirects into a sticky FAULT state.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pc_enable_i,
  input  logic             branch_taken_i,
  input  logic [XLEN-1:0]  branch_target_i,
  fetch_unit_if.master     mem,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  instr_o,
  output logic [6:0]       opcode_o,
  output logic             instr_valid_o,
  output logic             stall_o,
  output logic             fetch_fault_o
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FAULT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;

  // Request is gated by resetn so a reset mid-fetch drops it in the same cycle.
  assign mem.mem_req  = resetn && (state_q == S_REQ);
  assign mem.mem_addr = pc_q;

  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign opcode_o      = instr_q[6:0];
  assign instr_valid_o = (state_q == S_HOLD);
  assign stall_o       = ~instr_valid_o;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign fetch_fault_o = fault_q;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^branch_target_i[1:0];
  assign fetch_fault_o  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_d = fault_q;
`endif
    case (state_q)
      S_REQ: begin
        if (mem.mem_ready) begin
          instr_d = mem.mem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pc_enable_i) begin
          state_d = S_REQ;
          if (branch_taken_i) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            pc_d = branch_target_i;
            if (branch_target_i[1:0] != 2'b00) begin
              fault_d = 1'b1;
              state_d = S_FAULT;
            end
`else
            pc_d = {branch_target_i[XLEN-1:2], 2'b00};
`endif
          end else begin
            pc_d = pc_q + XLEN'(4);
          end
        end
      end
      default: ; // FAULT is terminal until reset
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed test-plan walk followed by randomized traffic, all checked
// against a transaction-level model of the fetch stage.
module tb_fetch_unit;
  localparam int XLEN = 32;
  localparam logic [31:0] RST_PC = 32'h0;

  logic clk = 1'b0;
  logic resetn;
  logic pc_enable, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc, instr;
  logic [6:0]  opcode;
  logic instr_valid, stall, fetch_fault;

  fetch_unit_if #(.XLEN(XLEN)) mif ();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk(clk), .resetn(resetn),
    .pc_enable_i(pc_enable), .branch_taken_i(branch_taken), .branch_target_i(branch_target),
    .mem(mif),
    .pc_o(pc), .instr_o(instr), .opcode_o(opcode),
    .instr_valid_o(instr_valid), .stall_o(stall), .fetch_fault_o(fetch_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: what instruction (if any) is held, where the PC points, whether trapped.
  logic [31:0] m_pc, m_instr;
  bit m_have, m_fault;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] tgt;
    if (!resetn) begin
      m_pc = RST_PC; m_instr = '0; m_have = 0; m_fault = 0;
    end else if (m_fault) begin
      // trapped: nothing moves
    end else if (!m_have) begin
      if (mif.mem_ready) begin m_instr = mif.mem_rdata; m_have = 1; end
    end else if (pc_enable) begin
      m_have = 0;
      if (!branch_taken) m_pc = m_pc + 32'd4;
      else begin
        tgt = branch_target;
`ifdef FETCH_MISALIGN_CHECK_EN
        m_pc = tgt;
        if (tgt % 4 != 0) m_fault = 1;
`else
        m_pc = tgt - (tgt % 4);
`endif
      end
    end
  endtask

  task automatic check_all();
    chk("mem_req",     {31'd0, mif.mem_req}, {31'd0, resetn && !m_have && !m_fault});
    chk("mem_addr",    mif.mem_addr, m_pc);
    chk("pc",          pc, m_pc);
    chk("instr",       instr, m_instr);
    chk("opcode",      {25'd0, opcode}, {25'd0, m_instr[6:0]});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_have});
    chk("stall",       {31'd0, stall}, {31'd0, !m_have});
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
  endtask

  task automatic drive(input logic rst, input logic en, input logic tk,
                       input logic [31:0] tgt, input logic rdy, input logic [31:0] rd);
    resetn = rst; pc_enable = en; branch_taken = tk; branch_target = tgt;
    mif.mem_ready = rdy; mif.mem_rdata = rd;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00500093);
    m_pc = RST_PC; m_instr = '0; m_have = 0; m_fault = 0;
    #1;
    chk("req_gated_rst", {31'd0, mif.mem_req}, 32'd0);
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);

    // Reset release with ready tied high: one-cycle fetch.
    resetn = 1'b1;
    #1;
    chk("rel_req", {31'd0, mif.mem_req}, 32'd1);
    chk("rel_addr", mif.mem_addr, 32'h0);
    step();
    chk("first_op", {25'd0, opcode}, 32'h13);
    chk("first_stall", {31'd0, stall}, 32'd0);

    // Wait states on the next fetch.
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      chk("ws_req", {31'd0, mif.mem_req}, 32'd1);
      chk("ws_addr", mif.mem_addr, 32'h4);
      step();
    end
    mif.mem_ready = 1'b1; mif.mem_rdata = 32'h002081B3;
    chk("ws_req4", {31'd0, mif.mem_req}, 32'd1);
    step();
    chk("ws_op", {25'd0, opcode}, 32'h33);
    chk("ws_valid", {31'd0, instr_valid}, 32'd1);

    // Branch to 0x100, fetch, then sequential advance.
    drive(1'b1, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00000013);
    step();
    chk("hold_pc100", pc, 32'h100);
    pc_enable = 1'b1; mif.mem_ready = 1'b0;
    step();
    chk("seq_pc", pc, 32'h104);
    chk("seq_req", {31'd0, mif.mem_req}, 32'd1);
    chk("seq_valid", {31'd0, instr_valid}, 32'd0);
    step(); // pc_enable during REQ is ignored
    chk("req_en_ign", pc, 32'h104);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00000013);
    step();

    // Redirect to 0x40.
    drive(1'b1, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
    step();
    chk("br_pc", pc, 32'h40);
    chk("br_addr", mif.mem_addr, 32'h40);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00000013);
    step();

    // Wrap from the top of the address space.
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    step();
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00000013);
    step();
    drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    chk("wrap_pc", pc, 32'h0);

    // Reset while a fetch is outstanding.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    resetn = 1'b0;
    #1;
    chk("midrst_req", {31'd0, mif.mem_req}, 32'd0);
    mif.mem_ready = 1'b1;
    step();
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_valid", {31'd0, instr_valid}, 32'd0);

    // Misaligned redirect.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00000013);
    step();
    drive(1'b1, 1'b1, 1'b1, 32'h42, 1'b1, 32'h00000013);
    step();
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, i[0], 1'b0, 32'h0, 1'b1, 32'h00000013);
      step();
      chk("mis_noreq", {31'd0, mif.mem_req}, 32'd0);
    end
`else
    chk("mis_pc", pc, 32'h40);
    chk("mis_nofault", {31'd0, fetch_fault}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h00000013);
    step();
    chk("mis_fetch", {31'd0, instr_valid}, 32'd1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom;
      if ($urandom_range(7) != 0) tgt[1:0] = 2'b00;
      drive($urandom_range(99) != 0, $urandom_range(1), $urandom_range(2) == 0,
            tgt, $urandom_range(1), $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
